// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared constants for the GPIO port bank.
//   - Register address map used on the 2-bit register bus address.
//   - Reset values for the output latch and the TRIS direction register,
//     sized for the widest supported port (16 bits); users slice them down
//     to the configured port width.
// Optional feature macro (used by the importing modules): GPIO_OPEN_DRAIN_EN
// -----------------------------------------------------------------------------
package gpio_pkg;

    // Register addresses within one port
    localparam logic [1:0] GPIO_A_PORT    = 2'd0;
    localparam logic [1:0] GPIO_A_TRIS    = 2'd1;
    localparam logic [1:0] GPIO_A_IOCMASK = 2'd2;
    localparam logic [1:0] GPIO_A_ODC     = 2'd3;

    // Widest port supported by the bank
    localparam int GPIO_MAX_WIDTH = 16;

    // All pins come out of reset as inputs with the latch cleared
    localparam logic [GPIO_MAX_WIDTH-1:0] TRIS_RST  = 16'hFFFF;
    localparam logic [GPIO_MAX_WIDTH-1:0] LATCH_RST = 16'h0000;

endpackage : gpio_pkg

// File: rtl/gpio_port_slice.sv
// -----------------------------------------------------------------------------
// gpio_port_slice
// One WIDTH-bit GPIO port: output latch, TRIS direction register, IOC mask,
// optional open-drain control (ODC), two-flop input synchroniser, change
// detect and sticky interrupt-on-change flags.
//
// Optional feature macro: GPIO_OPEN_DRAIN_EN
//   defined   : ODC register exists at address 3; ODC bits drive low only.
//   undefined : no ODC register; address 3 reads as zero, writes are dropped.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset
//   wr_en    in   write strobe, already qualified by the top's port select
//   rd_clr   in   PORT-register read of this port (clears flags)
//   addr     in   register address (see gpio_pkg)
//   wdata    in   write data
//   pad_in   in   raw asynchronous pad inputs
//   pad_out  out  value to the pad output buffers
//   pad_oe   out  pad output enables (1 = drive)
//   rd_val   out  combinational read value for the addressed register
//   irq_req  out  OR of (flag & mask) over this port
// -----------------------------------------------------------------------------
module gpio_port_slice
    import gpio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_clr,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] rd_val,
    output logic             irq_req
);

    logic [WIDTH-1:0] latch_q, latch_d;
    logic [WIDTH-1:0] tris_q,  tris_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [WIDTH-1:0] flag_q,  flag_d;
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] chg_s;
    logic [WIDTH-1:0] odc_s;
    logic [WIDTH-1:0] pin_sel_s;

`ifdef GPIO_OPEN_DRAIN_EN
    logic [WIDTH-1:0] odc_q, odc_d;

    // ODC next-state: loaded only by an address-3 write to this port
    always_comb begin
        odc_d = odc_q;
        if (wr_en && (addr == GPIO_A_ODC)) begin
            odc_d = wdata;
        end else begin
            odc_d = odc_q;
        end
    end

    // ODC register
    always_ff @(posedge clock) begin
        if (reset) begin
            odc_q <= '0;
        end else begin
            odc_q <= odc_d;
        end
    end

    assign odc_s = odc_q;
`else
    // Without the open-drain option every pin is push-pull
    assign odc_s = '0;
`endif

    // Bits whose edge arrives at s2 this cycle
    assign chg_s = s2_q ^ prev_q;

    // Open-drain bits always read the pin, as do input bits
    assign pin_sel_s = tris_q | odc_s;

    // Register write decode for latch, TRIS and mask
    always_comb begin
        latch_d = latch_q;
        tris_d  = tris_q;
        mask_d  = mask_q;
        if (wr_en) begin
            case (addr)
                GPIO_A_PORT:    latch_d = wdata;
                GPIO_A_TRIS:    tris_d  = wdata;
                GPIO_A_IOCMASK: mask_d  = wdata;
                default: begin
                    latch_d = latch_q;
                    tris_d  = tris_q;
                    mask_d  = mask_q;
                end
            endcase
        end else begin
            latch_d = latch_q;
            tris_d  = tris_q;
            mask_d  = mask_q;
        end
    end

    // Sticky flags: a PORT read clears them, a same-cycle change re-sets (set wins)
    always_comb begin
        flag_d = flag_q;
        if (rd_clr) begin
            flag_d = chg_s & mask_q;
        end else begin
            flag_d = flag_q | (chg_s & mask_q);
        end
    end

    // Read value for the addressed register
    always_comb begin
        rd_val = '0;
        case (addr)
            GPIO_A_PORT:    rd_val = (s2_q & pin_sel_s) | (latch_q & ~pin_sel_s);
            GPIO_A_TRIS:    rd_val = tris_q;
            GPIO_A_IOCMASK: rd_val = mask_q;
            GPIO_A_ODC:     rd_val = odc_s;
            default:        rd_val = '0;
        endcase
    end

    // Port state, synchroniser and change-detect history
    always_ff @(posedge clock) begin
        if (reset) begin
            latch_q <= LATCH_RST[WIDTH-1:0];
            tris_q  <= TRIS_RST[WIDTH-1:0];
            mask_q  <= '0;
            flag_q  <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
        end else begin
            latch_q <= latch_d;
            tris_q  <= tris_d;
            mask_q  <= mask_d;
            flag_q  <= flag_d;
            s1_q    <= pad_in;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
        end
    end

    // Open-drain bits never drive high: enable only while the latch is 0
    assign pad_oe  = ~tris_q & ~(odc_s & latch_q);
    assign pad_out = latch_q & ~odc_s;
    assign irq_req = |(flag_q & mask_q);

endmodule : gpio_port_slice

// File: rtl/gpio_port_bank.sv
// -----------------------------------------------------------------------------
// gpio_port_bank
// NPORTS GPIO ports of WIDTH bits behind a simple register bus. The top level
// decodes the port select, registers the read data and the combined
// interrupt; each port lives in a gpio_port_slice.
//
// Optional feature macro: GPIO_OPEN_DRAIN_EN (open-drain control register at
// address 3, handled inside each slice).
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset
//   sel      in   port index for the access (>= NPORTS: no port)
//   addr     in   0=PORT 1=TRIS 2=IOCMASK 3=ODC
//   we       in   write strobe
//   re       in   read strobe
//   wdata    in   write data
//   rdata    out  registered read data
//   rvalid   out  high one cycle after re
//   pad_in   in   raw pad inputs, port p at [p*WIDTH +: WIDTH]
//   pad_out  out  latch values to the pads
//   pad_oe   out  pad output enables (1 = drive)
//   irq      out  registered OR over all ports of (flag & mask)
// -----------------------------------------------------------------------------
module gpio_port_bank
    import gpio_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int WIDTH  = 8,
    parameter int PSEL_W = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [PSEL_W-1:0]       sel,
    input  logic [1:0]              addr,
    input  logic                    we,
    input  logic                    re,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    rvalid,
    input  logic [NPORTS*WIDTH-1:0] pad_in,
    output logic [NPORTS*WIDTH-1:0] pad_out,
    output logic [NPORTS*WIDTH-1:0] pad_oe,
    output logic                    irq
);

    // One-hot port select; an out-of-range sel matches no port, so it
    // writes nothing, clears nothing and reads back zero.
    logic [NPORTS-1:0] sel_hit_s;
    logic [NPORTS-1:0] irq_req_s;
    logic [WIDTH-1:0]  rd_val_s [NPORTS];
    logic [WIDTH-1:0]  rd_mux_s;

    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              irq_q, irq_d;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        assign sel_hit_s[p] = (32'(sel) == p);

        gpio_port_slice #(
            .WIDTH (WIDTH)
        ) u_slice (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (we & sel_hit_s[p]),
            .rd_clr  (re & sel_hit_s[p] & (addr == GPIO_A_PORT)),
            .addr    (addr),
            .wdata   (wdata),
            .pad_in  (pad_in[p*WIDTH +: WIDTH]),
            .pad_out (pad_out[p*WIDTH +: WIDTH]),
            .pad_oe  (pad_oe[p*WIDTH +: WIDTH]),
            .rd_val  (rd_val_s[p]),
            .irq_req (irq_req_s[p])
        );
    end

    // AND-OR read mux over the one-hot select (zero when nothing selected)
    always_comb begin
        rd_mux_s = '0;
        for (int p = 0; p < NPORTS; p++) begin
            rd_mux_s = rd_mux_s | (rd_val_s[p] & {WIDTH{sel_hit_s[p]}});
        end
    end

    // Read pipeline next state: rdata holds between reads
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = re;
        irq_d    = |irq_req_s;
        if (re) begin
            rdata_d = rd_mux_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign irq    = irq_q;

endmodule : gpio_port_bank

// File: tb/tb_gpio_port_bank.sv
// -----------------------------------------------------------------------------
// tb_gpio_port_bank
// Directed scenarios followed by randomized register traffic and pad
// activity, compared each cycle against a behavioural model that tracks the
// register contents, the pad history and the sticky flags.
// -----------------------------------------------------------------------------
module tb_gpio_port_bank;

    localparam int NP = 3;
    localparam int W  = 8;
    localparam int PW = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [PW-1:0]     sel;
    logic [1:0]        addr;
    logic              we;
    logic              re;
    logic [W-1:0]      wdata;
    logic [W-1:0]      rdata;
    logic              rvalid;
    logic [NP*W-1:0]   pad_in;
    logic [NP*W-1:0]   pad_out;
    logic [NP*W-1:0]   pad_oe;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [W-1:0]    m_latch [NP];
    logic [W-1:0]    m_tris  [NP];
    logic [W-1:0]    m_mask  [NP];
    logic [W-1:0]    m_odc   [NP];
    logic [W-1:0]    m_flag  [NP];
    logic            m_irq;
    logic [W-1:0]    m_rdata;
    logic            m_rvalid;
    // Pad values applied 1, 2 and 3 edges before the coming edge
    logic [NP*W-1:0] hist1, hist2, hist3;
    logic [NP*W-1:0] cur_pad;

    gpio_port_bank #(
        .NPORTS (NP),
        .WIDTH  (W),
        .PSEL_W (PW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .sel     (sel),
        .addr    (addr),
        .we      (we),
        .re      (re),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .pad_in  (pad_in),
        .pad_out (pad_out),
        .pad_oe  (pad_oe),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] m_read(input int p, input logic [1:0] a);
        logic [W-1:0] pins;
        logic [W-1:0] use_pin;
        pins    = hist2[p*W +: W];
        use_pin = m_tris[p] | m_odc[p];
        case (a)
            2'd0:    return (pins & use_pin) | (m_latch[p] & ~use_pin);
            2'd1:    return m_tris[p];
            2'd2:    return m_mask[p];
            default: return m_odc[p];
        endcase
    endfunction

    function automatic logic [NP*W-1:0] exp_oe();
        logic [NP*W-1:0] v;
        for (int p = 0; p < NP; p++) v[p*W +: W] = ~m_tris[p] & ~(m_odc[p] & m_latch[p]);
        return v;
    endfunction

    function automatic logic [NP*W-1:0] exp_out();
        logic [NP*W-1:0] v;
        for (int p = 0; p < NP; p++) v[p*W +: W] = m_latch[p] & ~m_odc[p];
        return v;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_latch[p] = 8'h00;
            m_tris[p]  = 8'hFF;
            m_mask[p]  = 8'h00;
            m_odc[p]   = 8'h00;
            m_flag[p]  = 8'h00;
        end
        m_irq = 1'b0; m_rdata = 8'h00; m_rvalid = 1'b0;
        hist1 = '0; hist2 = '0; hist3 = '0;
    endtask

    // Advance the model by one clock edge with the given bus inputs
    task automatic model_step(input logic w, input logic r, input int s, input logic [1:0] a,
                              input logic [W-1:0] d, input logic [NP*W-1:0] pad);
        logic          irq_next;
        logic [W-1:0]  chg;
        irq_next = 1'b0;
        for (int p = 0; p < NP; p++) irq_next |= |(m_flag[p] & m_mask[p]);
        if (r) begin
            m_rvalid = 1'b1;
            m_rdata  = (s < NP) ? m_read(s, a) : 8'h00;
        end else begin
            m_rvalid = 1'b0;
        end
        for (int p = 0; p < NP; p++) begin
            chg = hist2[p*W +: W] ^ hist3[p*W +: W];
            if (r && s == p && a == 2'd0) m_flag[p] = 8'h00;
            m_flag[p] |= chg & m_mask[p];
        end
        m_irq = irq_next;
        if (w && s < NP) begin
            case (a)
                2'd0: m_latch[s] = d;
                2'd1: m_tris[s]  = d;
                2'd2: m_mask[s]  = d;
                default: begin
`ifdef GPIO_OPEN_DRAIN_EN
                    m_odc[s] = d;
`endif
                end
            endcase
        end
        hist3 = hist2; hist2 = hist1; hist1 = pad;
    endtask

    task automatic compare_all();
        check_eq("rvalid", 32'(rvalid), 32'(m_rvalid));
        if (m_rvalid) check_eq("rdata", 32'(rdata), 32'(m_rdata));
        check_eq("pad_oe", 32'(pad_oe), 32'(exp_oe()));
        check_eq("pad_out", 32'(pad_out), 32'(exp_out()));
        check_eq("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic cycle(input logic w, input logic r, input logic [PW-1:0] s, input logic [1:0] a,
                         input logic [W-1:0] d);
        @(negedge clock);
        reset = 1'b0; we = w; re = r; sel = s; addr = a; wdata = d; pad_in = cur_pad;
        model_step(w, r, int'(s), a, d, cur_pad);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; we = 1'($urandom); re = 1'($urandom); sel = PW'($urandom);
        addr = 2'($urandom); wdata = W'($urandom); pad_in = cur_pad;
        model_reset();
        @(posedge clock);
        #1;
        check_eq("rst_rdata", 32'(rdata), 32'h0);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; re = 1'b0; sel = '0; addr = '0; wdata = '0;
        cur_pad = 24'h000000; pad_in = cur_pad;
        do_reset();

        // 1: reset state of TRIS and output enables
        cycle(1'b0, 1'b1, 2'd0, 2'd1, 8'h00);
        check_eq("t1_tris_rd", 32'(rdata), 32'hFF);
        check_eq("t1_rvalid", 32'(rvalid), 32'h1);
        check_eq("t1_pad_oe", 32'(pad_oe), 32'h0);

        // 2: port 1 upper nibble input, lower nibble output
        cur_pad = 24'h003000;
        cycle(1'b1, 1'b0, 2'd1, 2'd1, 8'hF0);
        cycle(1'b1, 1'b0, 2'd1, 2'd0, 8'hA5);
        check_eq("t2_pad_oe", 32'(pad_oe[15:8]), 32'h0F);
        check_eq("t2_pad_out", 32'(pad_out[15:8]), 32'hA5);
        cycle(1'b0, 1'b1, 2'd1, 2'd0, 8'h00);
        check_eq("t2_port_rd", 32'(rdata), 32'h35);

        // Simultaneous write/read of the same register returns the old value
        cycle(1'b1, 1'b1, 2'd1, 2'd1, 8'h3C);
        check_eq("wr_rd_old", 32'(rdata), 32'hF0);
        cycle(1'b1, 1'b1, 2'd1, 2'd1, 8'hF0);
        check_eq("wr_rd_new", 32'(rdata), 32'h3C);

        // 3: interrupt-on-change on port 2 bit 0
        cycle(1'b1, 1'b0, 2'd2, 2'd2, 8'h01);
        cur_pad[16] = 1'b1;
        idle(3);
        check_eq("t3_irq_early", 32'(irq), 32'h0);
        idle(1);
        check_eq("t3_irq_set", 32'(irq), 32'h1);
        cycle(1'b0, 1'b1, 2'd2, 2'd0, 8'h00);
        idle(1);
        check_eq("t3_irq_clr", 32'(irq), 32'h0);

        // 4: change arriving on the clearing read keeps the flag
        cur_pad[16] = 1'b0;
        idle(3);
        cur_pad[16] = 1'b1;
        idle(2);
        cycle(1'b0, 1'b1, 2'd2, 2'd0, 8'h00);
        idle(2);
        check_eq("t4_irq_kept", 32'(irq), 32'h1);
        // Clearing the mask drops irq while the flag stays
        cycle(1'b1, 1'b0, 2'd2, 2'd2, 8'h00);
        idle(1);
        check_eq("t4_mask_off", 32'(irq), 32'h0);
        cycle(1'b1, 1'b0, 2'd2, 2'd2, 8'h01);
        idle(1);
        check_eq("t4_mask_on", 32'(irq), 32'h1);
        cycle(1'b0, 1'b1, 2'd2, 2'd0, 8'h00);
        idle(1);

        // 5: out-of-range port select
        cycle(1'b0, 1'b1, 2'd3, 2'd1, 8'h00);
        check_eq("t5_rdata", 32'(rdata), 32'h0);
        check_eq("t5_rvalid", 32'(rvalid), 32'h1);
        cycle(1'b1, 1'b0, 2'd3, 2'd1, 8'h00);
        cycle(1'b1, 1'b0, 2'd3, 2'd0, 8'hFF);
        check_eq("t5_oe_kept", 32'(pad_oe), 32'h000F00);
        check_eq("t5_out_kept", 32'(pad_out), 32'h00A500);

        // 6: open-drain control register
        cycle(1'b1, 1'b0, 2'd0, 2'd3, 8'hFF);
`ifdef GPIO_OPEN_DRAIN_EN
        cycle(1'b1, 1'b0, 2'd0, 2'd1, 8'h00);
        cycle(1'b1, 1'b0, 2'd0, 2'd0, 8'h0F);
        check_eq("t6_od_oe", 32'(pad_oe[7:0]), 32'hF0);
        check_eq("t6_od_out", 32'(pad_out[7:0]), 32'h00);
`else
        cycle(1'b0, 1'b1, 2'd0, 2'd3, 8'h00);
        check_eq("t6_odc_rd", 32'(rdata), 32'h0);
        check_eq("t6_odc_rv", 32'(rvalid), 32'h1);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 0) cur_pad[$urandom_range(0, NP*W-1)] ^= 1'b1;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                      PW'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), W'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gpio_port_bank
